// File: rtl/mux_3to1_32bit_pkg.sv
// Purpose: shared select encodings for the 3:1 operand/writeback selector.
// Latency: n/a (constants only).
// Backpressure: n/a (no handshake).
package mux_3to1_32bit_pkg;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_C   = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

endpackage

// File: rtl/mux_3to1_32bit.sv
// Purpose: 3:1 datapath selector with a registered copy and a sticky illegal-select flag.
// Latency: X is combinational (0 cycles); X_q and sel_err update one cycle after the select.
// Backpressure: none; always accepts and always presents, no valid/ready.
module mux_3to1_32bit
    import mux_3to1_32bit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ILLEGAL_Z = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_q,
    output logic             sel_err
);

    // Encoding 2'b11 has no operand; legacy builds fall back to A, others force zero
    // so a bad select can never leak a stale or undefined value into the datapath.
    localparam bit LEGACY_FALLBACK = (ILLEGAL_Z != 0);

    // Select the operand; default arm covers the illegal encoding and avoids latches.
    always_comb begin
        X = '0;
        case (S)
            SEL_A:   X = A;
            SEL_B:   X = B;
            SEL_C:   X = C;
            default: X = LEGACY_FALLBACK ? A : '0;
        endcase
    end

    // Register the selected value and latch any illegal select seen on a clock edge;
    // reset clears both asynchronously but leaves the combinational path untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X_q     <= '0;
            sel_err <= 1'b0;
        end else begin
            X_q <= X;
            if (S == SEL_BAD) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_3to1_32bit.sv
// Purpose: randomized + directed scoreboard bench for mux_3to1_32bit (both fallback modes).
// Latency: combinational X checked right after drive; X_q/sel_err checked one edge later.
// Backpressure: none; monitor pops one expectation per clock edge when one is queued.
module tb_mux_3to1_32bit;

    typedef struct packed {
        logic [31:0] xq0;
        logic [31:0] xq1;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  S;
    logic [31:0] A, B, C;
    logic [31:0] X0, Xq0, X1, Xq1;
    logic        err0, err1;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    bit   model_err = 1'b0;

    mux_3to1_32bit #(.WIDTH(32), .ILLEGAL_Z(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .S(S), .A(A), .B(B), .C(C),
        .X(X0), .X_q(Xq0), .sel_err(err0)
    );

    mux_3to1_32bit #(.WIDTH(32), .ILLEGAL_Z(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .S(S), .A(A), .B(B), .C(C),
        .X(X1), .X_q(Xq1), .sel_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick from an operand list by index; index 3 has no operand.
    function automatic logic [31:0] ref_x(input logic [1:0] s, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input bit legacy);
        logic [31:0] opts [3];
        opts[0] = a;
        opts[1] = b;
        opts[2] = c;
        if (s == 2'd3) return legacy ? a : 32'd0;
        return opts[s];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one set of inputs away from the edge, check X now, queue the registered result.
    task automatic drive(input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        @(negedge clk);
        S = s; A = a; B = b; C = c;
        #1;
        check("x_zero_mode", X0, ref_x(s, a, b, c, 1'b0));
        check("x_legacy_mode", X1, ref_x(s, a, b, c, 1'b1));
        if (s == 2'd3) model_err = 1'b1;
        e.xq0 = ref_x(s, a, b, c, 1'b0);
        e.xq1 = ref_x(s, a, b, c, 1'b1);
        e.err = model_err;
        sb_q.push_back(e);
    endtask

    // Monitor: one registered sample per edge, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("xq_zero_mode", Xq0, e.xq0);
                check("xq_legacy_mode", Xq1, e.xq1);
                check("sel_err_zero_mode", {31'd0, err0}, {31'd0, e.err});
                check("sel_err_legacy_mode", {31'd0, err1}, {31'd0, e.err});
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        S = 2'b00; A = 32'd1; B = 32'd2; C = 32'd3;
        #3;
        check("reset_xq", Xq0, 32'd0);
        check("reset_sel_err", {31'd0, err0}, 32'd0);
        check("x_valid_in_reset", X0, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: each legal select, then illegal, then back to legal (flag stays set).
        drive(2'b00, 32'd1, 32'd2, 32'd3);
        drive(2'b01, 32'd1, 32'd2, 32'd3);
        drive(2'b10, 32'd1, 32'd2, 32'd3);
        drive(2'b11, 32'd1, 32'd2, 32'd3);
        drive(2'b00, 32'd1, 32'd2, 32'd3);
        drive(2'b00, 32'd1, 32'd2, 32'd3);

        // Asynchronous reset between edges: outputs clear at once, X keeps tracking S.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_xq0", Xq0, 32'd0);
        check("async_clear_xq1", Xq1, 32'd0);
        check("async_clear_err", {31'd0, err0}, 32'd0);
        S = 2'b10;
        #1;
        check("x_tracks_in_reset", X0, 32'd3);
        model_err = 1'b0;
        e.xq0 = 32'd0; e.xq1 = 32'd0; e.err = 1'b0;
        sb_q.push_back(e);
        // Release mid-activity: the first edge captures the current X.
        @(negedge clk);
        rst_n = 1'b1;
        S = 2'b01; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
        e.xq0 = ref_x(S, A, B, C, 1'b0);
        e.xq1 = ref_x(S, A, B, C, 1'b1);
        e.err = 1'b0;
        sb_q.push_back(e);

        // Bit-exact extremes across the legal selects.
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                drive(s[1:0], 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0000);
            end
        end

        // Randomized traffic, illegal select kept rare so the flag's set point moves.
        for (int i = 0; i < 200; i++) begin
            logic [1:0] rs;
            rs = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            drive(rs, $urandom, $urandom, $urandom);
        end

        // Drain the scoreboard within a bounded number of edges.
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
